// File: rtl/pwm_sample_sequencer.sv
// pwm_sample_sequencer: FIFO-buffered PCM samples played out as a registered PWM stream at a fixed sample rate.
module pwm_sample_sequencer #(
  parameter int DUTY_WIDTH         = 10,
  parameter int PERIODS_PER_SAMPLE = 4,
  parameter int DEPTH              = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic [DUTY_WIDTH-1:0]        sample_data,
  input  logic                         sample_valid,
  output logic                         sample_ready,
  input  logic                         clear_underflow,
  output logic                         pwm_out,
  output logic                         underflow,
  output logic [$clog2(DEPTH+1)-1:0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = (PERIODS_PER_SAMPLE > 1) ? $clog2(PERIODS_PER_SAMPLE) : 1;
  logic [DUTY_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         rd_ptr, wr_ptr;
  logic [DUTY_WIDTH-1:0] duty, pwm_cnt, pwm_cnt_nxt;
  logic [PW-1:0]         per_cnt, per_cnt_nxt;
  logic [LW-1:0]         level_nxt;
  logic                  full, empty, push, load, pop, wrap, per_last;
  assign full         = level == LW'(DEPTH);
  assign empty        = level == '0;
  assign sample_ready = !full;
  assign push         = sample_valid && sample_ready;
  assign wrap         = &pwm_cnt;
  assign per_last     = per_cnt == PW'(PERIODS_PER_SAMPLE - 1);
  assign load         = enable && wrap && per_last;
  assign pop          = load && !empty;
  always_comb begin
    pwm_cnt_nxt = enable ? pwm_cnt + 1'b1 : '0;
    per_cnt_nxt = !enable ? '0 : !wrap ? per_cnt : per_last ? '0 : per_cnt + 1'b1;
    level_nxt   = (push && !pop) ? level + LW'(1) : (pop && !push) ? level - LW'(1) : level;
  end
  // Storage carries no reset; occupancy and pointers alone define valid entries.
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= sample_data;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      level     <= '0;
      duty      <= '0;
      pwm_cnt   <= '0;
      per_cnt   <= '0;
      pwm_out   <= 1'b0;
      underflow <= 1'b0;
    end else begin
      rd_ptr    <= pop ? rd_ptr + 1'b1 : rd_ptr;
      wr_ptr    <= push ? wr_ptr + 1'b1 : wr_ptr;
      level     <= level_nxt;
      duty      <= pop ? mem[rd_ptr] : duty;
      pwm_cnt   <= pwm_cnt_nxt;
      per_cnt   <= per_cnt_nxt;
      pwm_out   <= enable && (pwm_cnt < duty);
      underflow <= (load && empty) ? 1'b1 : clear_underflow ? 1'b0 : underflow;
    end
  end
endmodule

// File: tb/tb_pwm_sample_sequencer.sv
// tb_pwm_sample_sequencer: directed checks of reset, playback, backpressure, underflow, disable and FIFO ordering.
module tb_pwm_sample_sequencer;
  logic       clk = 1'b0;
  logic       rst_n, enable, sample_valid, clear_underflow;
  logic [9:0] sample_data;
  logic       sample_ready, pwm_out, underflow;
  logic [3:0] level;
  logic       s_enable, s_valid, s_ready, s_pwm, s_uf;
  logic [3:0] s_data, s_level;
  int n_cmp = 0, n_err = 0;
  int hi, first, w;
  int ph [9];
  int sv [20];
  always #5 clk = ~clk;
  pwm_sample_sequencer dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sample_data(sample_data),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .clear_underflow(clear_underflow), .pwm_out(pwm_out),
    .underflow(underflow), .level(level)
  );
  // Short period and sample interval so the 16-load ordering run stays cheap.
  pwm_sample_sequencer #(.DUTY_WIDTH(4), .PERIODS_PER_SAMPLE(2), .DEPTH(8)) dut_small (
    .clk(clk), .rst_n(rst_n), .enable(s_enable), .sample_data(s_data),
    .sample_valid(s_valid), .sample_ready(s_ready),
    .clear_underflow(1'b0), .pwm_out(s_pwm),
    .underflow(s_uf), .level(s_level)
  );
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic push(input logic [9:0] d);
    sample_valid = 1'b1;
    sample_data  = d;
    step;
    sample_valid = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0; enable = 1'b0; sample_valid = 1'b0; sample_data = '0; clear_underflow = 1'b0;
    s_enable = 1'b0; s_valid = 1'b0; s_data = '0;
    for (int i = 0; i < 20; i++) sv[i] = (i * 7 + 3) % 16;
    #12;
    chk("init_level", level, 0);
    chk("init_ready", sample_ready, 1);
    chk("init_pwm", pwm_out, 0);
    chk("init_uf", underflow, 0);
    step;
    rst_n = 1'b1;
    step;
    // single sample playback, then underflow with held duty
    push(10'd256);
    chk("ss_level_push", level, 1);
    enable = 1'b1;
    first = -1;
    for (int p = 0; p < 9; p++) ph[p] = 0;
    for (int k = 1; k <= 9216; k++) begin
      step;
      if (pwm_out === 1'b1) begin
        ph[(k - 1) / 1024]++;
        if (first < 0) first = k;
      end
      if (k == 4095) chk("ss_level_preload", level, 1);
      if (k == 4096) begin
        chk("ss_level_load", level, 0);
        chk("ss_uf_load", underflow, 0);
      end
      if (k == 4352) chk("ss_pwm_last_hi", pwm_out, 1);
      if (k == 4353) chk("ss_pwm_first_lo", pwm_out, 0);
      if (k == 8191) chk("ss_uf_pre", underflow, 0);
      if (k == 8192) chk("ss_uf_set", underflow, 1);
    end
    for (int p = 0; p < 9; p++) chk($sformatf("ss_highs_p%0d", p), ph[p], (p < 4) ? 0 : 256);
    chk("ss_first_high", first, 4097);
    // underflow clear, and set-over-clear priority
    clear_underflow = 1'b1;
    step;
    chk("uf_clear_idle", underflow, 0);
    clear_underflow = 1'b0;
    for (int k = 9218; k <= 12287; k++) step;
    clear_underflow = 1'b1;
    step;
    chk("uf_set_wins", underflow, 1);
    step;
    chk("uf_clear_next", underflow, 0);
    clear_underflow = 1'b0;
    for (int k = 12290; k <= 16384; k++) step;
    chk("uf_reset_again", underflow, 1);
    push(10'd1); push(10'd2); push(10'd3);
    chk("rst_pre_level", level, 3);
    chk("rst_pre_pwm", pwm_out, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_async_level", level, 0);
    chk("rst_async_pwm", pwm_out, 0);
    chk("rst_async_uf", underflow, 0);
    chk("rst_async_ready", sample_ready, 1);
    enable = 1'b0;
    step; step;
    rst_n = 1'b1;
    step;
    // backpressure on a full FIFO
    for (int i = 0; i < 8; i++) push(10'(300 + i * 40));
    chk("bp_level_full", level, 8);
    chk("bp_ready_full", sample_ready, 0);
    sample_valid = 1'b1;
    sample_data  = 10'd999;
    step; step;
    chk("bp_hold_level", level, 8);
    chk("bp_hold_ready", sample_ready, 0);
    sample_valid = 1'b0;
    enable = 1'b1;
    hi = 0;
    for (int k = 1; k <= 5120; k++) begin
      step;
      if (k == 4095) chk("bp_level_preload", level, 8);
      if (k == 4096) begin
        chk("bp_level_load", level, 7);
        chk("bp_ready_load", sample_ready, 1);
      end
      if (k > 4096 && pwm_out === 1'b1) hi++;
    end
    chk("bp_first_duty", hi, 300);
    enable = 1'b0;
    step;
    rst_n = 1'b0;
    step;
    rst_n = 1'b1;
    step;
    // disable mid-period with duty 512
    push(10'd512);
    enable = 1'b1;
    for (int k = 1; k <= 4196; k++) step;
    chk("dis_pwm_before", pwm_out, 1);
    enable = 1'b0;
    step;
    chk("dis_pwm_off", pwm_out, 0);
    chk("dis_level", level, 0);
    push(10'd77);
    chk("dis_push_level", level, 1);
    repeat (5) step;
    chk("dis_pwm_idle", pwm_out, 0);
    enable = 1'b1;
    hi = 0;
    first = -1;
    for (int i = 1; i <= 1024; i++) begin
      step;
      if (pwm_out === 1'b1) begin
        hi++;
        if (first < 0) first = i;
      end
    end
    chk("reen_highs", hi, 512);
    chk("reen_first", first, 1);
    chk("reen_level", level, 1);
    chk("reen_uf", underflow, 0);
    enable = 1'b0;
    step;
    // simultaneous push/pop ordering on the small instance
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1;
      s_data  = 4'(sv[i]);
      step;
    end
    s_valid = 1'b0;
    chk("pp_level_init", s_level, 4);
    s_enable = 1'b1;
    hi = 0;
    for (int j = 1; j <= 544; j++) begin
      if (j % 32 == 0 && j <= 512) begin
        s_valid = 1'b1;
        s_data  = 4'(sv[j / 32 + 3]);
      end else s_valid = 1'b0;
      step;
      if (s_pwm === 1'b1) hi++;
      if (j % 32 == 0) begin
        if (j <= 512) chk($sformatf("pp_level_%0d", j / 32), s_level, 4);
        w = j / 32 - 1;
        chk($sformatf("pp_order_w%0d", w), hi, (w == 0) ? 0 : 2 * sv[w - 1]);
        hi = 0;
      end
    end
    s_valid = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pwm_sample_sequencer.md
# pwm_sample_sequencer

Audio sample scheduler for the board's PWM audio output. It accepts PCM duty samples from a requester over a valid/ready interface and buffers them in a small FIFO. At a fixed sample rate it loads the next sample into the duty register and drives a registered PWM bit stream toward the `aud_pwm` output flop. It runs entirely in the `pwm_clk_g` (150 MHz) domain.

## Interface

Parameters:
- `DUTY_WIDTH`, default 10: sample and duty width. The PWM period is 2^DUTY_WIDTH cycles.
- `PERIODS_PER_SAMPLE`, default 4: number of PWM periods each sample is held (≥1).
- `DEPTH`, default 8: sample FIFO depth. Must be a power of two, ≥2.

Ports (one clock; reset is asynchronous and active-low):
- `clk`, in, 1: PWM-domain clock.
- `rst_n`, in, 1: asynchronous active-low reset.
- `enable`, in, 1: playback enable, synchronous.
- `sample_data`, in, DUTY_WIDTH: unsigned duty sample.
- `sample_valid`, in, 1: sample offered.
- `sample_ready`, out, 1: FIFO can accept a sample; equals !full.
- `clear_underflow`, in, 1: synchronous clear of the sticky flag.
- `pwm_out`, out, 1: registered PWM bit.
- `underflow`, out, 1: sticky; set when a sample load found the FIFO empty.
- `level`, out, $clog2(DEPTH+1): FIFO occupancy.

## Operation

- FIFO:
  - Push when `sample_valid && sample_ready`.
  - Pop only at a load event.
  - Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - `level` is tracked explicitly and is exact at 0 and DEPTH.
  - Push and pop in the same cycle: `level` is unchanged, both pointers advance.
- Counters:
  - `pwm_cnt` (DUTY_WIDTH bits) increments every cycle while `enable`=1 and wraps from 2^DUTY_WIDTH−1 to 0.
  - `per_cnt` counts 0..PERIODS_PER_SAMPLE−1 and advances when `pwm_cnt` wraps.
- Load event: `enable && pwm_cnt==all-ones && per_cnt==PERIODS_PER_SAMPLE−1`.
  - FIFO non-empty: `duty` ← FIFO head, pop.
  - FIFO empty: `duty` holds its value, `underflow` ← 1.
  - A push in the same cycle as a load on an empty FIFO is not bypassed. The sample enters the FIFO and underflow still sets.
- PWM: `pwm_out` ← `enable && (pwm_cnt < duty)`, registered.
  - duty=0 gives a constant low output.
  - duty=2^DUTY_WIDTH−1 gives high for all but one cycle per period.
- `enable`=0:
  - `pwm_cnt` and `per_cnt` are forced to 0 and `pwm_out` goes to 0 on the next edge.
  - `duty` and the FIFO contents are retained, and the FIFO still accepts pushes.
  - Re-enable restarts at the beginning of a period with the held duty.
- Underflow flag:
  - `clear_underflow` clears it.
  - Set has priority over clear when both occur in the same cycle.

## Timing

- Reset (`rst_n`=0, async) sets all of the following, with no clock required:
  - `pwm_out`=0, `underflow`=0, `level`=0, `sample_ready`=1.
  - `duty`=0, `pwm_cnt`=0, `per_cnt`=0, FIFO pointers 0.
- Deassertion of `rst_n` is synchronous to the design; the first increment happens on the first edge after release with `enable`=1.
- `sample_ready` is combinational from the full state only and does not depend on `sample_valid`.
- Pushed data is visible in `level` one cycle after the handshake edge.
- Latency:
  - The loaded duty takes effect for `pwm_cnt`=0 of the following period.
  - `pwm_out` lags the `pwm_cnt` comparison by one cycle.
  - Each PWM period is exactly 2^DUTY_WIDTH cycles.
  - A sample is output for exactly PERIODS_PER_SAMPLE periods.
- Full FIFO with a load event in the same cycle: `sample_ready` was 0, so no push occurs. The pop reduces `level` to DEPTH−1 and `sample_ready`=1 on the next cycle.
- `rst_n` asserted mid-period or mid-FIFO: all state is lost immediately and queued samples are discarded.

## Test plan

- Reset:
  - Drive `rst_n`=0 asynchronously mid-clock with the FIFO holding 3 samples.
  - Required: `level`=0, `pwm_out`=0, `underflow`=0, `sample_ready`=1 immediately, without a clock edge.
- Single sample:
  - Defaults. Push 256, then `enable`=1.
  - Required:
    - The first 4 periods use duty 0 (low for 4096 cycles).
    - The next 4 periods are each exactly 256 high cycles followed by 768 low, with `pwm_out` high starting one cycle after `pwm_cnt`=0.
    - After that, `underflow`=1 and duty holds at 256.
- Backpressure:
  - Push 8 samples with `enable`=0.
  - Required:
    - `level`=8 and `sample_ready`=0; a 9th valid is held and not accepted.
    - After enabling, at the first load `level`=7 and `sample_ready`=1 on the next cycle.
- Underflow priority:
  - Assert `clear_underflow` on the same cycle as an empty-FIFO load.
  - Required: `underflow` remains 1; a clear one cycle later drops it to 0.
- Disable mid-period:
  - Deassert `enable` at `pwm_cnt`=100 with duty 512.
  - Required:
    - `pwm_out`=0 on the next edge; `level` and `duty` are unchanged.
    - After re-enable, `pwm_out` is high for 512 cycles starting 1 cycle after enable.
- Simultaneous push and pop:
  - Hold `level`=4 and push on the load cycle.
  - Required: `level` stays 4; the output order of samples matches push order over 16 loads.
